// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Programmable event prescaler for the timer unit. Divides the
//                tick_i event stream by (compare + 1) and emits one registered
//                single-cycle tick_o pulse per period. Compare updates made
//                while counting are shadowed and take effect only at a period
//                boundary (wrap or clear), so periods are never cut short or
//                stretched.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             clear_i,
    input  logic             update_i,
    input  logic [WIDTH-1:0] cfg_compare_i,
    input  logic             tick_i,
    output logic             tick_o,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] compare_o,
    output logic             pending_o
);

    // ------------------------------------------------------------------------
    // Operating mode
    //   S_IDLE     : counting disabled, compare writes go straight through
    //   S_RUN      : counting, no compare change outstanding
    //   S_RUN_PEND : counting, a new compare waits in the shadow register
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_RUN_PEND = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] compare_q;
    logic [WIDTH-1:0] compare_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic             tick_q;
    logic             tick_d;

    logic             pend_w;
    logic             wrap_w;
    logic             boundary_w;
    logic             apply_shadow_w;

    // A shadowed compare is outstanding only in the pending run mode.
    assign pend_w = (state_q == S_RUN_PEND);

    // Wrap: an accepted tick while enabled and not being cleared, with the
    // count at or beyond compare. Using >= lets a count stranded above a
    // freshly lowered compare finish on the very next tick, and it also
    // guarantees count+1 can never overflow the register.
    assign wrap_w = active_i & ~clear_i & tick_i & (count_q >= compare_q);

    // Period boundary while running: either a natural wrap or a clear.
    assign boundary_w = clear_i | wrap_w;

    // The shadow is committed at a boundary, or when counting stops so that a
    // stopped prescaler never hides a pending value.
    assign apply_shadow_w = pend_w & (~active_i | boundary_w);

    // Mode register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode: leaving the enabled state always lands in IDLE; a new update
    // while enabled always (re)arms the pending state, even on the same cycle
    // that an older pending value is being committed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (active_i) begin
                    state_d = update_i ? S_RUN_PEND : S_RUN;
                end
            end
            S_RUN: begin
                if (!active_i) begin
                    state_d = S_IDLE;
                end else if (update_i) begin
                    state_d = S_RUN_PEND;
                end
            end
            S_RUN_PEND: begin
                if (!active_i) begin
                    state_d = S_IDLE;
                end else if (update_i) begin
                    state_d = S_RUN_PEND;
                end else if (boundary_w) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: count, compare, shadow and the output pulse.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        shadow_d  = shadow_q;
        tick_d    = 1'b0;

        // Clear outranks ticking and also works while stopped; a tick in the
        // same cycle as a clear is dropped.
        if (clear_i) begin
            count_d = '0;
        end else if (active_i && tick_i) begin
            if (wrap_w) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        // Commit the older shadowed value first; the wrap that commits it
        // still used the previous compare for its own decision.
        if (apply_shadow_w) begin
            compare_d = shadow_q;
        end

        // Stopped: the new compare goes live on the next edge.
        // Running: it is parked in the shadow until the next boundary.
        if (update_i) begin
            if (active_i) begin
                shadow_d = cfg_compare_i;
            end else begin
                compare_d = cfg_compare_i;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= '0;
            shadow_q  <= '0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            shadow_q  <= shadow_d;
            tick_q    <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pend_w;

endmodule
`default_nettype wire

// File: tb/tb_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_prescaler
//  Description : Self-checking bench for timer_prescaler. A behavioural model
//                tracks count/compare/shadow as plain values and is compared
//                against the DUT every cycle; directed sequences add literal
//                expectations, followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_prescaler;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         active_i;
    logic         clear_i;
    logic         update_i;
    logic [W-1:0] cfg_compare_i;
    logic         tick_i;
    logic         tick_o;
    logic [W-1:0] count_o;
    logic [W-1:0] compare_o;
    logic         pending_o;

    int errors = 0;
    int checks = 0;

    timer_prescaler #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .active_i      (active_i),
        .clear_i       (clear_i),
        .update_i      (update_i),
        .cfg_compare_i (cfg_compare_i),
        .tick_i        (tick_i),
        .tick_o        (tick_o),
        .count_o       (count_o),
        .compare_o     (compare_o),
        .pending_o     (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [W-1:0] count;
        logic [W-1:0] compare;
        logic [W-1:0] shadow;
        logic         pend;
        logic         tick;
    } mstate_t;

    mstate_t m;
    logic    m_valid = 1'b0;

    // One period = compare+1 accepted ticks; a new compare written while
    // counting waits until the period ends (wrap/clear) or counting stops.
    function automatic mstate_t model_step(input mstate_t s);
        mstate_t n;
        logic    ends_period;
        n           = s;
        n.tick      = 1'b0;
        ends_period = 1'b0;
        if (!active_i) begin
            if (s.pend) n.compare = s.shadow;
            n.pend = 1'b0;
            if (update_i) n.compare = cfg_compare_i;
            if (clear_i) n.count = '0;
        end else begin
            if (clear_i) begin
                n.count     = '0;
                ends_period = 1'b1;
            end else if (tick_i) begin
                if (int'(s.count) >= int'(s.compare)) begin
                    n.count     = '0;
                    n.tick      = 1'b1;
                    ends_period = 1'b1;
                end else begin
                    n.count = W'(int'(s.count) + 1);
                end
            end
            if (ends_period && s.pend) begin
                n.compare = s.shadow;
                n.pend    = 1'b0;
            end
            if (update_i) begin
                n.shadow = cfg_compare_i;
                n.pend   = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            m       <= '0;
            m_valid <= 1'b1;
        end else begin
            m <= model_step(m);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (m_valid) begin
            check("model_tick_o",    32'(tick_o),    32'(m.tick));
            check("model_count_o",   32'(count_o),   32'(m.count));
            check("model_compare_o", 32'(compare_o), 32'(m.compare));
            check("model_pending_o", 32'(pending_o), 32'(m.pend));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply one cycle of inputs; on return the outputs reflect that cycle.
    task automatic cyc(input logic act, input logic clr, input logic upd,
                       input logic [W-1:0] cfg, input logic tk);
        rst_i         = 1'b0;
        active_i      = act;
        clear_i       = clr;
        update_i      = upd;
        cfg_compare_i = cfg;
        tick_i        = tk;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        active_i = 1'b0;
        clear_i  = 1'b0;
        update_i = 1'b0;
        tick_i   = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic set_cmp(input logic [W-1:0] v);
        cyc(1'b0, 1'b0, 1'b1, v, 1'b0);
    endtask

    int pulses;

    initial begin
        rst_i = 1'b1; active_i = 1'b0; clear_i = 1'b0; update_i = 1'b0;
        cfg_compare_i = '0; tick_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state
        do_reset();
        check("reset_count",   32'(count_o),   0);
        check("reset_compare", 32'(compare_o), 0);
        check("reset_pending", 32'(pending_o), 0);
        check("reset_tick",    32'(tick_o),    0);

        // Basic divide by 4
        set_cmp(8'd3);
        check("div_compare_idle", 32'(compare_o), 3);
        check("div_pending_idle", 32'(pending_o), 0);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
            check("div_count", 32'(count_o), 32'(i % 4));
            if (tick_o) pulses++;
        end
        check("div_pulses", 32'(pulses), 3);

        // compare=0 pass-through, ticks on cycles 0,1,5
        set_cmp(8'd0);
        begin
            logic [6:0] pat;
            pat = 7'b0100011;
            for (int k = 0; k < 7; k++) begin
                cyc(1'b1, 1'b0, 1'b0, '0, pat[k]);
                check("pass_tick", 32'(tick_o), 32'(pat[k]));
                check("pass_count", 32'(count_o), 0);
            end
        end

        // Shadowed update
        set_cmp(8'd4);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_count_start", 32'(count_o), 2);
        cyc(1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        check("shadow_pending", 32'(pending_o), 1);
        check("shadow_compare_held", 32'(compare_o), 4);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_no_early_apply", 32'(compare_o), 4);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_wrap_tick", 32'(tick_o), 1);
        check("shadow_wrap_compare", 32'(compare_o), 1);
        check("shadow_wrap_pending", 32'(pending_o), 0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_p2_mid", 32'(tick_o), 0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_p2_tick", 32'(tick_o), 1);
        cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'd6, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("shadow_last_wins", 32'(compare_o), 6);

        // Clear racing a tick with a pending shadow
        set_cmp(8'd2);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
        check("clear_pre_count", 32'(count_o), 2);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("clear_count", 32'(count_o), 0);
        check("clear_no_tick", 32'(tick_o), 0);
        check("clear_applied", 32'(compare_o), 7);
        check("clear_pending", 32'(pending_o), 0);

        // Lowered compare while stopped
        repeat (5) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'd2, 1'b1);
        check("lower_frozen_count", 32'(count_o), 5);
        check("lower_compare", 32'(compare_o), 2);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("lower_count", 32'(count_o), 0);
        check("lower_tick", 32'(tick_o), 1);

        // Reset with a pending update at count 7
        set_cmp(8'd9);
        repeat (7) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        check("rst_pre_count", 32'(count_o), 7);
        check("rst_pre_pending", 32'(pending_o), 1);
        do_reset();
        check("rst_count", 32'(count_o), 0);
        check("rst_compare", 32'(compare_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_tick", 32'(tick_o), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
            check("rst_follow_tick", 32'(tick_o), 1);
        end

        // Maximum compare: count reaches all-ones, then wraps
        set_cmp(8'd255);
        repeat (255) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("max_count_top", 32'(count_o), 255);
        check("max_no_tick", 32'(tick_o), 0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("max_wrap_count", 32'(count_o), 0);
        check("max_wrap_tick", 32'(tick_o), 1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                logic [W-1:0] cfg;
                cfg = ($urandom_range(0, 4) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
                cyc($urandom_range(0, 9) != 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 11) == 0,
                    cfg,
                    $urandom_range(0, 3) != 0);
            end
        end

        @(posedge clk_i);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
